gx_wpar_drain: RTL and testbench

Drain sequencer for the GX write-gather pipe buffer in the CP path. It waits for the 32-byte gather buffer to report full, pulls its two 128-bit halves, and writes them as a two-beat burst into the CPU-side command FIFO ring in main memory. It then advances the ring write pointer, wrapping from end back to base. It sits between the gather buffer and the memory write port; the PI register block supplies its configuration.

---
 rtl/gx_wpar_drain.sv | 149 ++++++++++++++
 tb/tb_gx_wpar_drain.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gx_wpar_drain.sv
// Drain sequencer: moves one full 32-byte gather buffer into the CP command FIFO ring as a
// two-beat burst, then advances the ring write pointer. Optional wrap flag: GXWPAR_WRAP_FLAG_EN.
module gx_wpar_drain #(
   parameter int unsigned ADDR_W = 26
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic              fifo_full,
   output logic              fifo_read,
   input  logic [127:0]      fifo_data,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_end,
   input  logic              cfg_wptr_load,
   input  logic [ADDR_W-1:0] cfg_wptr_val,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [127:0]      mem_wdata,
   output logic              mem_last,
   output logic [ADDR_W-1:0] wptr,
   output logic              busy
`ifdef GXWPAR_WRAP_FLAG_EN
   ,
   output logic              wrap
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH0,
      BEAT0,
      FETCH1,
      BEAT1,
      COMMIT
   } state_t;

   state_t            r_state;
   logic              r_fifo_read;
   logic              r_mem_valid;
   logic              r_mem_last;
   logic [ADDR_W-1:0] r_wptr;
   logic              r_pend;
   logic [ADDR_W-1:0] r_pend_val;

   logic [ADDR_W-1:0] w_ld_val;
   logic [ADDR_W-1:0] w_next;
   logic              w_wraps;
   logic              w_pend_hit;
   logic [ADDR_W-1:0] w_pend_val;

   assign w_ld_val   = cfg_wptr_val & ~ADDR_W'(5'h1F);
   assign w_next     = r_wptr + ADDR_W'(32);
   assign w_wraps    = (w_next >= cfg_end);
   // A strobe landing in COMMIT itself is honoured like a pending load rather than dropped.
   assign w_pend_hit = r_pend | cfg_wptr_load;
   assign w_pend_val = cfg_wptr_load ? w_ld_val : r_pend_val;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_fifo_read <= 1'b0;
         r_mem_valid <= 1'b0;
         r_mem_last  <= 1'b0;
         r_wptr      <= '0;
         r_pend      <= 1'b0;
         r_pend_val  <= '0;
      end else begin
         r_fifo_read <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cfg_wptr_load)
                  r_wptr <= w_ld_val;
               if (fifo_full && enable) begin
                  r_fifo_read <= 1'b1;
                  r_state     <= FETCH0;
               end
            end
            FETCH0: begin
               r_mem_valid <= 1'b1;
               r_mem_last  <= 1'b0;
               r_state     <= BEAT0;
            end
            BEAT0: begin
               if (mem_ready) begin
                  r_mem_valid <= 1'b0;
                  r_fifo_read <= 1'b1;
                  r_state     <= FETCH1;
               end
            end
            FETCH1: begin
               r_mem_valid <= 1'b1;
               r_mem_last  <= 1'b1;
               r_state     <= BEAT1;
            end
            BEAT1: begin
               if (mem_ready) begin
                  r_mem_valid <= 1'b0;
                  r_mem_last  <= 1'b0;
                  r_state     <= COMMIT;
               end
            end
            COMMIT: begin
               if (w_pend_hit)
                  r_wptr <= w_pend_val;
               else if (w_wraps)
                  r_wptr <= cfg_base;
               else
                  r_wptr <= w_next;
               r_pend  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
         if (cfg_wptr_load && r_state != IDLE && r_state != COMMIT) begin
            r_pend     <= 1'b1;
            r_pend_val <= w_ld_val;
         end
      end
   end

`ifdef GXWPAR_WRAP_FLAG_EN
   logic r_wrap;

   always_ff @(posedge clk) begin
      if (!resetn)
         r_wrap <= 1'b0;
      else if (r_state == IDLE && cfg_wptr_load)
         r_wrap <= 1'b0;
      else if (r_state == COMMIT) begin
         if (w_pend_hit)
            r_wrap <= 1'b0;
         else if (w_wraps)
            r_wrap <= 1'b1;
      end
   end

   assign wrap = r_wrap;
`endif

   assign fifo_read = r_fifo_read;
   assign mem_valid = r_mem_valid;
   assign mem_last  = r_mem_last;
   assign mem_addr  = r_wptr;
   assign mem_wdata = fifo_data;
   assign wptr      = r_wptr;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_gx_wpar_drain.sv
// Bench for gx_wpar_drain: directed test-plan bursts plus random traffic against a
// phase-level reference model and an emulated gather buffer.
module tb_gx_wpar_drain;
   localparam int unsigned AW = 26;

   logic          clk = 1'b0;
   logic          resetn, enable, fifo_full, fifo_read, cfg_wptr_load;
   logic          mem_valid, mem_ready, mem_last, busy;
   logic [127:0]  fifo_data, mem_wdata;
   logic [AW-1:0] cfg_base, cfg_end, cfg_wptr_val, mem_addr, wptr;
`ifdef GXWPAR_WRAP_FLAG_EN
   logic          wrap;
`endif

   always #5 clk = ~clk;

   gx_wpar_drain #(.ADDR_W(AW)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .fifo_full(fifo_full),
      .fifo_read(fifo_read), .fifo_data(fifo_data), .cfg_base(cfg_base),
      .cfg_end(cfg_end), .cfg_wptr_load(cfg_wptr_load), .cfg_wptr_val(cfg_wptr_val),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_last(mem_last), .wptr(wptr), .busy(busy)
`ifdef GXWPAR_WRAP_FLAG_EN
      , .wrap(wrap)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;

   // reference model: ph 0 idle, 1 read lo, 2 beat lo, 3 read hi, 4 beat hi, 5 commit
   int            ph = 0;
   logic [AW-1:0] m_wptr = '0;
   logic [AW-1:0] m_pv = '0;
   bit            m_pend = 0;
   bit            m_wrap = 0;
   logic [255:0]  m_chunk = '0;

   logic [255:0]  buf_q[$];
   int            rd_cnt = 0;

   int            n_reads = 0;
   int            n_beats = 0;
   logic [127:0]  beat_d[2];
   bit            beat_l[2];
   logic [AW-1:0] beat_a = '0;

   bit            p_stall = 0;
   logic [AW-1:0] p_addr;
   logic [127:0]  p_data;
   logic          p_last;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] align(input logic [AW-1:0] v);
      logic [AW-1:0] r;
      r = v;
      r[4:0] = '0;
      return r;
   endfunction

   task automatic m_step();
      int p0;
      longint n;
      p0 = ph;
      if (!resetn) begin
         ph = 0; m_wptr = '0; m_pend = 0; m_wrap = 0;
         return;
      end
      case (p0)
         0: begin
            if (cfg_wptr_load) begin m_wptr = align(cfg_wptr_val); m_wrap = 0; end
            if (fifo_full && enable) begin ph = 1; m_chunk = buf_q[0]; end
         end
         1: ph = 2;
         2: if (mem_ready) ph = 3;
         3: ph = 4;
         4: if (mem_ready) ph = 5;
         default: begin
            if (m_pend || cfg_wptr_load) begin
               m_wptr = cfg_wptr_load ? align(cfg_wptr_val) : m_pv;
               m_wrap = 0;
            end else begin
               n = (longint'(m_wptr) + 32) % (longint'(1) << AW);
               if (n >= longint'(cfg_end)) begin m_wptr = cfg_base; m_wrap = 1; end
               else m_wptr = AW'(n);
            end
            m_pend = 0;
            ph = 0;
         end
      endcase
      if (p0 >= 1 && p0 <= 4 && cfg_wptr_load) begin m_pend = 1; m_pv = align(cfg_wptr_val); end
   endtask

   // one clock: record handshake, predict, advance, compare, let the buffer react
   task automatic tick();
      if (mem_valid === 1'b1 && mem_ready) begin
         beat_d[n_beats % 2] = mem_wdata;
         beat_l[n_beats % 2] = mem_last;
         if (mem_last !== 1'b1) beat_a = mem_addr;
         n_beats++;
      end
      p_stall = (mem_valid === 1'b1) && !mem_ready;
      p_addr = mem_addr; p_data = mem_wdata; p_last = mem_last;
      m_step();
      @(negedge clk);
      chk("fifo_read", 128'(fifo_read), 128'(ph == 1 || ph == 3));
      chk("mem_valid", 128'(mem_valid), 128'(ph == 2 || ph == 4));
      chk("mem_last", 128'(mem_last), 128'(ph == 4));
      chk("busy", 128'(busy), 128'(ph != 0));
      chk("wptr", 128'(wptr), 128'(m_wptr));
      chk("mem_addr", 128'(mem_addr), 128'(m_wptr));
      chk("wdata_pass", mem_wdata, fifo_data);
      if (ph == 2) chk("beat_lo", mem_wdata, m_chunk[127:0]);
      if (ph == 4) chk("beat_hi", mem_wdata, m_chunk[255:128]);
`ifdef GXWPAR_WRAP_FLAG_EN
      chk("wrap", 128'(wrap), 128'(m_wrap));
`endif
      if (p_stall && resetn) begin
         chk("hold_valid", 128'(mem_valid), 128'(1'b1));
         chk("hold_addr", 128'(mem_addr), 128'(p_addr));
         chk("hold_data", mem_wdata, p_data);
         chk("hold_last", 128'(mem_last), 128'(p_last));
      end
      if (fifo_read === 1'b1) n_reads++;
      if (!resetn) begin
         buf_q.delete();
         rd_cnt = 0;
      end else if (fifo_read === 1'b1 && buf_q.size() > 0) begin
         if (rd_cnt == 0) begin
            fifo_data = buf_q[0][127:0];
            rd_cnt = 1;
         end else begin
            fifo_data = buf_q[0][255:128];
            void'(buf_q.pop_front());
            rd_cnt = 0;
         end
      end
      fifo_full = (buf_q.size() > 0);
   endtask

   task automatic push(input logic [255:0] c);
      buf_q.push_back(c);
      fifo_full = 1'b1;
   endtask

   function automatic logic [255:0] rnd_chunk();
      logic [255:0] c;
      for (int i = 0; i < 8; i++) c[32*i +: 32] = $urandom;
      return c;
   endfunction

   task automatic load(input logic [AW-1:0] v);
      cfg_wptr_load = 1'b1;
      cfg_wptr_val = v;
      tick();
      cfg_wptr_load = 1'b0;
   endtask

   task automatic run_burst(input int w0, input int w1, input bit do_ld,
                            input logic [AW-1:0] ldv, input bit drop_en, input bit do_rst);
      int c0, c1;
      bit started, ld_done, done;
      c0 = 0; c1 = 0; started = 0; ld_done = 0; done = 0;
      enable = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         mem_ready = 1'b1;
         if (ph == 2) begin
            if (c0 < w0) begin mem_ready = 1'b0; c0++; end
            if (do_ld && !ld_done) begin cfg_wptr_load = 1'b1; cfg_wptr_val = ldv; ld_done = 1; end
         end
         if (ph == 4) begin
            if (c1 < w1) begin mem_ready = 1'b0; c1++; end
            if (drop_en) enable = 1'b0;
         end
         if (ph == 3 && do_rst) resetn = 1'b0;
         if (ph != 0) started = 1;
         tick();
         cfg_wptr_load = 1'b0;
         resetn = 1'b1;
         if (started && ph == 0) done = 1;
      end
      chk("burst_done", 128'(done), 128'(1'b1));
      enable = 1'b0;
      mem_ready = 1'b1;
   endtask

   initial begin
      logic [255:0] c;
      resetn = 1'b0; enable = 1'b0; fifo_full = 1'b0; fifo_data = '0;
      cfg_base = AW'('h1000); cfg_end = AW'('h2000);
      cfg_wptr_load = 1'b0; cfg_wptr_val = '0; mem_ready = 1'b1;
      tick();
      tick();
      resetn = 1'b1;
      chk("reset_wptr", 128'(wptr), 128'(0));
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_valid", 128'(mem_valid), 128'(0));
      chk("reset_read", 128'(fifo_read), 128'(0));

      // basic drain with byte ramp
      load(AW'('h1000));
      chk("basic_load", 128'(wptr), 128'('h1000));
      for (int i = 0; i < 32; i++) c[8*i +: 8] = 8'(i);
      push(c);
      n_reads = 0; n_beats = 0;
      enable = 1'b1;
      repeat (5) tick();
      chk("n5_busy", 128'(busy), 128'(1));
      chk("n5_wptr", 128'(wptr), 128'('h1000));
      tick();
      enable = 1'b0;
      chk("n6_busy", 128'(busy), 128'(0));
      chk("n6_wptr", 128'(wptr), 128'('h1020));
      chk("basic_beat0", beat_d[0], 128'h0F0E0D0C0B0A09080706050403020100);
      chk("basic_beat1", beat_d[1], 128'h1F1E1D1C1B1A19181716151413121110);
      chk("basic_addr", 128'(beat_a), 128'('h1000));
      chk("basic_last0", 128'(beat_l[0]), 128'(0));
      chk("basic_last1", 128'(beat_l[1]), 128'(1));
      chk("basic_reads", 128'(n_reads), 128'(2));

      // wrap at end of ring
      load(AW'('h1FE0));
      push(rnd_chunk());
      run_burst(0, 0, 0, '0, 0, 0);
      chk("wrap_addr", 128'(beat_a), 128'('h1FE0));
      chk("wrap_wptr", 128'(wptr), 128'('h1000));
`ifdef GXWPAR_WRAP_FLAG_EN
      chk("wrap_set", 128'(wrap), 128'(1));
`endif
      load(AW'('h1400));
      chk("wrap_reload", 128'(wptr), 128'('h1400));
`ifdef GXWPAR_WRAP_FLAG_EN
      chk("wrap_clear", 128'(wrap), 128'(0));
`endif

      // backpressure
      n_reads = 0; n_beats = 0;
      push(rnd_chunk());
      run_burst(5, 3, 0, '0, 0, 0);
      chk("bp_reads", 128'(n_reads), 128'(2));
      chk("bp_beats", 128'(n_beats), 128'(2));
      chk("bp_wptr", 128'(wptr), 128'('h1420));

      // load during BEAT0 overrides the increment
      push(rnd_chunk());
      run_burst(2, 0, 1, AW'('h1800), 0, 0);
      chk("mid_addr", 128'(beat_a), 128'('h1420));
      chk("mid_wptr", 128'(wptr), 128'('h1800));

      // enable low with a full buffer, then drop enable in BEAT1
      push(rnd_chunk());
      n_reads = 0; n_beats = 0;
      enable = 1'b0;
      repeat (6) tick();
      chk("dis_reads", 128'(n_reads), 128'(0));
      chk("dis_busy", 128'(busy), 128'(0));
      run_burst(0, 2, 0, '0, 1, 0);
      chk("drop_beats", 128'(n_beats), 128'(2));
      chk("drop_wptr", 128'(wptr), 128'('h1820));

      // carry out of the address width is discarded
      cfg_end = AW'('h3FFFFE0);
      load(AW'('h3FFFFE0));
      push(rnd_chunk());
      run_burst(0, 0, 0, '0, 0, 0);
      chk("carry_wptr", 128'(wptr), 128'(0));

      // base >= end still compares and wraps
      cfg_base = AW'('h2000); cfg_end = AW'('h1000);
      load(AW'('h1000));
      push(rnd_chunk());
      run_burst(0, 0, 0, '0, 0, 0);
      chk("badcfg_wptr", 128'(wptr), 128'('h2000));

      // reset in FETCH1 abandons the burst
      push(rnd_chunk());
      run_burst(0, 0, 0, '0, 0, 1);
      chk("rst_wptr", 128'(wptr), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_valid", 128'(mem_valid), 128'(0));
      chk("rst_read", 128'(fifo_read), 128'(0));
      chk("rst_last", 128'(mem_last), 128'(0));

      // random traffic
      cfg_base = AW'('h1000); cfg_end = AW'('h1200);
      for (int i = 0; i < 4000; i++) begin
         resetn = ($urandom_range(0, 599) != 0);
         enable = ($urandom_range(0, 3) != 0);
         mem_ready = ($urandom_range(0, 2) != 0);
         cfg_wptr_load = ($urandom_range(0, 19) == 0);
         cfg_wptr_val = AW'($urandom_range(0, 'h3000));
         if ($urandom_range(0, 199) == 0) begin
            cfg_base = AW'($urandom_range(0, 'h100) << 5);
            cfg_end = AW'($urandom_range(0, 'h100) << 5);
         end
         if (buf_q.size() < 2 && $urandom_range(0, 3) == 0) push(rnd_chunk());
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
